intersection_ctrl: RTL and testbench
====================================

# intersection_ctrl

Two-road traffic-intersection controller that sequences the main-road and side-road light heads plus a pedestrian walk signal. Built on the same Moore-style light FSM concept, it adds per-phase cycle timers, side-road vehicle demand and a latched pedestrian request. It sits between road sensors/push-buttons and the lamp drivers; all outputs are a pure decode of the state register.

## Interface
- GREEN_MIN, 8: minimum green duration (cycles), both roads
- GREEN_MAX, 20: maximum side-road green (cycles)
- YELLOW_T, 3: yellow duration (cycles)
- ALLRED_T, 2: all-red clearance duration (cycles)
- WALK_T, 6: pedestrian walk duration (cycles)
- CNT_W, 8: phase timer width; every duration parameter must be in 1..2^CNT_W

- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- side_req  in  1  side-road vehicle present (level)
- ped_req  in  1  pedestrian button (pulse or level; latched internally)
- main_red, main_yellow, main_green  out  1 each  main-road lamps
- side_red, side_yellow, side_green  out  1 each  side-road lamps
- walk  out  1  pedestrian walk lamp
- phase  out  3  current state code

## Operation
- States/codes: ALLRED_M=0, MAIN_GREEN=1, MAIN_YELLOW=2, ALLRED_S=3, SIDE_GREEN=4, SIDE_YELLOW=5, PED_WALK=6; code 7 is illegal -> ALLRED_M next cycle.
- Phase timer cnt: cleared to 0 on every state change, +1 each cycle in the same state. A fixed-duration state of length T exits on the edge where cnt==T-1, i.e. it occupies exactly T cycles.
- ALLRED_M: all red, ALLRED_T cycles -> MAIN_GREEN.
- MAIN_GREEN: main green, side red. Rest state: stays indefinitely without demand; cnt saturates at GREEN_MIN-1 (no wrap). Exits to MAIN_YELLOW on the first cycle with cnt==GREEN_MIN-1 and (side_req or ped_pend).
- MAIN_YELLOW: main yellow, side red, YELLOW_T cycles -> ALLRED_S.
- ALLRED_S: all red, ALLRED_T cycles; at exit side_req=1 -> SIDE_GREEN, else ped_pend -> PED_WALK, else -> ALLRED_M.
- SIDE_GREEN: side green, main red. Exits to SIDE_YELLOW when (cnt>=GREEN_MIN-1 and side_req=0) or cnt==GREEN_MAX-1 (hard cutoff regardless of side_req).
- SIDE_YELLOW: side yellow, main red, YELLOW_T cycles; exit -> PED_WALK if ped_pend else ALLRED_M.
- PED_WALK: both red, walk=1, WALK_T cycles -> ALLRED_M.
- ped_pend: set on any cycle with ped_req=1 while not in PED_WALK; cleared on the edge entering PED_WALK (clear wins over simultaneous set); ped_req during PED_WALK ignored.
- Exactly one lamp per head lit in every state; walk=1 only in PED_WALK.

## Timing
- Reset (rst_n=0, asynchronous, immediate): state=ALLRED_M, cnt=0, ped_pend=0; outputs main_red=1, side_red=1, all yellow/green=0, walk=0, phase=0. Reset mid-phase aborts it with no yellow.
- Outputs change in the same cycle as the state register (decode only, no extra register stage); a transition decided on edge n is visible after edge n.
- side_req and ped_req sampled on rising edge; side_req asserted on the exit cycle of ALLRED_S counts.
- Minimum demand-served main-to-side latency from a request at cnt>=GREEN_MIN-1 in MAIN_GREEN: 1 + YELLOW_T + ALLRED_T cycles to side green.

## Test plan
- Reset release, no requests: phase 0 for 2 cycles, then phase 1 with main_green=1 held for 100 cycles; cnt never wraps.
- side_req held 1 from reset: ALLRED_M 2, MAIN_GREEN 8, MAIN_YELLOW 3, ALLRED_S 2, SIDE_GREEN 20 (max cutoff), SIDE_YELLOW 3, ALLRED_M 2, MAIN_GREEN 8, repeat.
- side_req high until SIDE_GREEN cycle 3 then low: SIDE_GREEN lasts exactly 8 cycles (min), then SIDE_YELLOW 3 -> ALLRED_M.
- Single-cycle ped_req in MAIN_GREEN cycle 3, side_req=0: green ends after 8 cycles, yellow 3, ALLRED_S 2, PED_WALK 6 with walk=1, ALLRED_M 2, back to MAIN_GREEN; ped_pend cleared.
- ped_req pulse during SIDE_GREEN with side_req=1: after SIDE_YELLOW go to PED_WALK (6 cycles), then ALLRED_M; second ped_req pulse inside PED_WALK causes no extra walk.
- rst_n low asynchronously mid SIDE_GREEN with ped_pend=1: outputs immediately all red, walk=0, phase=0; after release no walk served without a new ped_req.

Source files
------------

// File: rtl/intersection_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : intersection_ctrl
// Description : Two-road intersection light sequencer with phase timers,
//               side-road demand and a latched pedestrian walk request.
// Revision    : 1.0 - initial release
// ============================================================================
module intersection_ctrl #(
    parameter int GREEN_MIN = 8,
    parameter int GREEN_MAX = 20,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 2,
    parameter int WALK_T    = 6,
    parameter int CNT_W     = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       side_req,
    input  logic       ped_req,
    output logic       main_red,
    output logic       main_yellow,
    output logic       main_green,
    output logic       side_red,
    output logic       side_yellow,
    output logic       side_green,
    output logic       walk,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        S_ALLRED_M    = 3'd0,
        S_MAIN_GREEN  = 3'd1,
        S_MAIN_YELLOW = 3'd2,
        S_ALLRED_S    = 3'd3,
        S_SIDE_GREEN  = 3'd4,
        S_SIDE_YELLOW = 3'd5,
        S_PED_WALK    = 3'd6
    } state_t;

    // Terminal timer values: a phase of length T leaves when the timer reads T-1.
    localparam logic [CNT_W-1:0] c_GMIN_LAST   = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] c_GMAX_LAST   = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] c_YELLOW_LAST = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] c_ALLRED_LAST = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] c_WALK_LAST   = CNT_W'(WALK_T - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_ped_pend;
    logic             w_ped_pend_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_ALLRED_M;
            r_cnt      <= '0;
            r_ped_pend <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_ped_pend <= w_ped_pend_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_ALLRED_M: begin
                if (r_cnt == c_ALLRED_LAST) w_state_nxt = S_MAIN_GREEN;
            end
            S_MAIN_GREEN: begin
                if ((r_cnt == c_GMIN_LAST) && (side_req || r_ped_pend))
                    w_state_nxt = S_MAIN_YELLOW;
            end
            S_MAIN_YELLOW: begin
                if (r_cnt == c_YELLOW_LAST) w_state_nxt = S_ALLRED_S;
            end
            S_ALLRED_S: begin
                if (r_cnt == c_ALLRED_LAST) begin
                    if (side_req)        w_state_nxt = S_SIDE_GREEN;
                    else if (r_ped_pend) w_state_nxt = S_PED_WALK;
                    else                 w_state_nxt = S_ALLRED_M;
                end
            end
            S_SIDE_GREEN: begin
                if (((r_cnt >= c_GMIN_LAST) && !side_req) || (r_cnt == c_GMAX_LAST))
                    w_state_nxt = S_SIDE_YELLOW;
            end
            S_SIDE_YELLOW: begin
                if (r_cnt == c_YELLOW_LAST)
                    w_state_nxt = r_ped_pend ? S_PED_WALK : S_ALLRED_M;
            end
            S_PED_WALK: begin
                if (r_cnt == c_WALK_LAST) w_state_nxt = S_ALLRED_M;
            end
            default: w_state_nxt = S_ALLRED_M;
        endcase
    end

    // Main green is the rest state, so its timer parks at the minimum rather than wrapping.
    always_comb begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (w_state_nxt != r_state)
            w_cnt_nxt = '0;
        else if ((r_state == S_MAIN_GREEN) && (r_cnt == c_GMIN_LAST))
            w_cnt_nxt = r_cnt;
    end

    always_comb begin
        w_ped_pend_nxt = r_ped_pend;
        if ((w_state_nxt == S_PED_WALK) && (r_state != S_PED_WALK))
            w_ped_pend_nxt = 1'b0;
        else if (ped_req && (r_state != S_PED_WALK))
            w_ped_pend_nxt = 1'b1;
    end

    always_comb begin
        main_red    = 1'b1;
        main_yellow = 1'b0;
        main_green  = 1'b0;
        side_red    = 1'b1;
        side_yellow = 1'b0;
        side_green  = 1'b0;
        walk        = 1'b0;
        case (r_state)
            S_MAIN_GREEN: begin
                main_red   = 1'b0;
                main_green = 1'b1;
            end
            S_MAIN_YELLOW: begin
                main_red    = 1'b0;
                main_yellow = 1'b1;
            end
            S_SIDE_GREEN: begin
                side_red   = 1'b0;
                side_green = 1'b1;
            end
            S_SIDE_YELLOW: begin
                side_red    = 1'b0;
                side_yellow = 1'b1;
            end
            S_PED_WALK: walk = 1'b1;
            default: ;
        endcase
    end

    assign phase = r_state;

endmodule
`default_nettype wire

// File: tb/tb_intersection_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_intersection_ctrl
// Description : Directed scoreboard bench for intersection_ctrl light sequencing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_intersection_ctrl;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       side_req = 1'b0;
    logic       ped_req  = 1'b0;
    logic       main_red, main_yellow, main_green;
    logic       side_red, side_yellow, side_green;
    logic       walk;
    logic [2:0] phase;

    int total = 0;
    int bad   = 0;
    logic [9:0] sb[$];
    logic [9:0] obs;

    intersection_ctrl #(
        .GREEN_MIN (8),
        .GREEN_MAX (20),
        .YELLOW_T  (3),
        .ALLRED_T  (2),
        .WALK_T    (6),
        .CNT_W     (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .side_req    (side_req),
        .ped_req     (ped_req),
        .main_red    (main_red),
        .main_yellow (main_yellow),
        .main_green  (main_green),
        .side_red    (side_red),
        .side_yellow (side_yellow),
        .side_green  (side_green),
        .walk        (walk),
        .phase       (phase)
    );

    always #5 clk = ~clk;

    assign obs = {phase, main_red, main_yellow, main_green,
                  side_red, side_yellow, side_green, walk};

    // Expected {phase, main r/y/g, side r/y/g, walk} for each phase code.
    function automatic logic [9:0] exp_vec(input logic [2:0] code);
        case (code)
            3'd0:    return {3'd0, 3'b100, 3'b100, 1'b0};
            3'd1:    return {3'd1, 3'b001, 3'b100, 1'b0};
            3'd2:    return {3'd2, 3'b010, 3'b100, 1'b0};
            3'd3:    return {3'd3, 3'b100, 3'b100, 1'b0};
            3'd4:    return {3'd4, 3'b100, 3'b001, 1'b0};
            3'd5:    return {3'd5, 3'b100, 3'b010, 1'b0};
            3'd6:    return {3'd6, 3'b100, 3'b100, 1'b1};
            default: return {3'd0, 3'b100, 3'b100, 1'b0};
        endcase
    endfunction

    task automatic check(input string tag);
        logic [9:0] e;
        e = sb.pop_front();
        total++;
        assert (obs === e) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, e);
        end
    endtask

    // n cycles expected in phase 'code' with the given inputs driven for each.
    task automatic seg(input logic [2:0] code, input int n, input logic s,
                       input logic p, input string tag);
        for (int i = 0; i < n; i++) begin
            side_req = s;
            ped_req  = p;
            sb.push_back(exp_vec(code));
            check(tag);
            @(negedge clk);
        end
        ped_req = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        sb.push_back(exp_vec(3'd0));
        check("reset_state");
        rst_n = 1'b1;

        // Idle: rest in main green, then a late request exits at once
        seg(3'd0, 2,   1'b0, 1'b0, "idle_allred");
        seg(3'd1, 100, 1'b0, 1'b0, "idle_main_green");
        seg(3'd1, 1,   1'b1, 1'b0, "late_req_cycle");
        seg(3'd2, 3,   1'b1, 1'b0, "late_req_yellow");
        seg(3'd3, 2,   1'b1, 1'b0, "late_req_allred_s");
        seg(3'd4, 1,   1'b1, 1'b0, "late_req_side_green");

        // Side held from reset: hard max cutoff
        #2 rst_n = 1'b0;
        #1 sb.push_back(exp_vec(3'd0));
        check("reset_mid_side");
        @(negedge clk);
        rst_n = 1'b1;
        seg(3'd0, 2,  1'b1, 1'b0, "held_allred_m");
        seg(3'd1, 8,  1'b1, 1'b0, "held_main_green");
        seg(3'd2, 3,  1'b1, 1'b0, "held_main_yellow");
        seg(3'd3, 2,  1'b1, 1'b0, "held_allred_s");
        seg(3'd4, 20, 1'b1, 1'b0, "held_side_max");
        seg(3'd5, 3,  1'b1, 1'b0, "held_side_yellow");
        seg(3'd0, 2,  1'b1, 1'b0, "held_allred_m2");
        seg(3'd1, 8,  1'b1, 1'b0, "held_main_green2");
        seg(3'd2, 3,  1'b1, 1'b0, "min_main_yellow");
        seg(3'd3, 2,  1'b1, 1'b0, "min_allred_s");

        // Side demand drops at side-green cycle 3: minimum green
        seg(3'd4, 2,  1'b1, 1'b0, "min_side_green_a");
        seg(3'd4, 6,  1'b0, 1'b0, "min_side_green_b");
        seg(3'd5, 3,  1'b0, 1'b0, "min_side_yellow");
        seg(3'd0, 2,  1'b0, 1'b0, "min_allred_m");

        // Pedestrian pulse in main green cycle 3
        seg(3'd1, 2,  1'b0, 1'b0, "ped_mg_a");
        seg(3'd1, 1,  1'b0, 1'b1, "ped_mg_pulse");
        seg(3'd1, 5,  1'b0, 1'b0, "ped_mg_b");
        seg(3'd2, 3,  1'b0, 1'b0, "ped_main_yellow");
        seg(3'd3, 2,  1'b0, 1'b0, "ped_allred_s");
        seg(3'd6, 6,  1'b0, 1'b0, "ped_walk");
        seg(3'd0, 2,  1'b0, 1'b0, "ped_allred_m");
        seg(3'd1, 20, 1'b0, 1'b0, "ped_cleared_rest");

        // Pedestrian pulse during side green, second pulse inside walk
        seg(3'd1, 1,  1'b1, 1'b0, "sp_exit");
        seg(3'd2, 3,  1'b1, 1'b0, "sp_main_yellow");
        seg(3'd3, 2,  1'b1, 1'b0, "sp_allred_s");
        seg(3'd4, 5,  1'b1, 1'b0, "sp_side_green_a");
        seg(3'd4, 1,  1'b1, 1'b1, "sp_side_green_ped");
        seg(3'd4, 14, 1'b1, 1'b0, "sp_side_green_b");
        seg(3'd5, 3,  1'b0, 1'b0, "sp_side_yellow");
        seg(3'd6, 2,  1'b0, 1'b0, "sp_walk_a");
        seg(3'd6, 1,  1'b0, 1'b1, "sp_walk_ped");
        seg(3'd6, 3,  1'b0, 1'b0, "sp_walk_b");
        seg(3'd0, 2,  1'b0, 1'b0, "sp_allred_m");
        seg(3'd1, 20, 1'b0, 1'b0, "sp_no_extra_walk");

        // Asynchronous reset in side green with a pedestrian pending
        seg(3'd1, 1,  1'b1, 1'b0, "rst_exit");
        seg(3'd2, 3,  1'b1, 1'b0, "rst_main_yellow");
        seg(3'd3, 2,  1'b1, 1'b0, "rst_allred_s");
        seg(3'd4, 3,  1'b1, 1'b0, "rst_side_green_a");
        seg(3'd4, 1,  1'b1, 1'b1, "rst_side_green_ped");
        seg(3'd4, 2,  1'b1, 1'b0, "rst_side_green_b");
        #2 rst_n = 1'b0;
        #1 sb.push_back(exp_vec(3'd0));
        check("async_reset_outputs");
        side_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        seg(3'd0, 2,  1'b0, 1'b0, "post_rst_allred_m");
        seg(3'd1, 20, 1'b0, 1'b0, "post_rst_no_walk");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
